// File: rtl/traceback_unit.sv
// Viterbi traceback engine: walks survivor memory back TB_DEPTH steps, then streams decoded bits oldest-first.
// Optional build macro TB_BEST_STATE_EN starts the walk from the minimum-metric state instead of i_start_state.
module traceback_unit #(
   parameter int STATE_W    = 6,
   parameter int TB_DEPTH   = 32,
   parameter int OUT_BITS   = 2,
   parameter int MEM_DEPTH  = 64,
   parameter int PM_W       = 8,
   localparam int NUM_STATES = 2**STATE_W,
   localparam int ADDR_W     = $clog2(MEM_DEPTH)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          i_start,
   input  logic [STATE_W-1:0]            i_start_state,
   input  logic [ADDR_W-1:0]             i_base_addr,
   output logic                          o_rd_en,
   output logic [ADDR_W-1:0]             o_rd_addr,
   input  logic [NUM_STATES*STATE_W-1:0] i_surv_data,
   output logic                          o_valid,
   input  logic                          i_ready,
   output logic [OUT_BITS-1:0]           o_data,
   output logic                          o_busy,
   output logic                          o_done,
   input  logic [NUM_STATES*PM_W-1:0]    i_path_metric
);

   localparam int CNT_W = $clog2(TB_DEPTH) + 1;
   localparam int IDX_W = $clog2(TB_DEPTH);

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_TRACE, S_OUTPUT, S_DONE} state_t;

   state_t               r_state, w_state_next;
   logic [STATE_W-1:0]   r_cur_state;
   logic [STATE_W-1:0]   w_prev_state;
   logic [STATE_W-1:0]   w_start_state;
   logic [ADDR_W-1:0]    r_addr;
   logic [CNT_W-1:0]     r_step;
   logic [CNT_W-1:0]     r_idx;
   logic [IDX_W-1:0]     w_rd_idx;
   logic [OUT_BITS-1:0]  r_buf [TB_DEPTH];
   logic                 w_last_step;
   logic                 w_last_beat;

`ifdef TB_BEST_STATE_EN
   logic [PM_W-1:0] w_best_pm;
   logic            w_unused_start;

   assign w_unused_start = ^i_start_state;

   // Strict less-than keeps the lowest index on ties.
   always_comb begin
      w_start_state = '0;
      w_best_pm     = i_path_metric[0 +: PM_W];
      for (int s = 1; s < NUM_STATES; s++) begin
         if (i_path_metric[s*PM_W +: PM_W] < w_best_pm) begin
            w_best_pm     = i_path_metric[s*PM_W +: PM_W];
            w_start_state = STATE_W'(s);
         end
      end
   end
`else
   logic w_unused_pm;

   assign w_unused_pm   = ^i_path_metric;
   assign w_start_state = i_start_state;
`endif

   assign w_prev_state = i_surv_data[r_cur_state*STATE_W +: STATE_W];
   assign w_last_step  = (r_step == CNT_W'(TB_DEPTH-1));
   assign w_last_beat  = (r_idx == CNT_W'(TB_DEPTH-1));
   assign w_rd_idx     = IDX_W'(TB_DEPTH-1) - r_idx[IDX_W-1:0];

   always_ff @(posedge clk) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:   if (i_start) w_state_next = S_FETCH;
         S_FETCH:  w_state_next = S_TRACE;
         S_TRACE:  w_state_next = w_last_step ? S_OUTPUT : S_FETCH;
         S_OUTPUT: if (i_ready && w_last_beat) w_state_next = S_DONE;
         S_DONE:   w_state_next = S_IDLE;
         default:  w_state_next = S_IDLE;
      endcase
   end

   always_comb begin
      o_rd_en = 1'b0;
      o_valid = 1'b0;
      o_done  = 1'b0;
      o_data  = '0;
      o_busy  = (r_state != S_IDLE);
      case (r_state)
         S_FETCH:  o_rd_en = 1'b1;
         S_OUTPUT: begin
            o_valid = 1'b1;
            o_data  = r_buf[w_rd_idx];
         end
         S_DONE:   o_done = 1'b1;
         default:  ;
      endcase
   end

   assign o_rd_addr = r_addr;

   // Survivor data for the FETCH address arrives during TRACE.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_cur_state <= '0;
         r_addr      <= '0;
         r_step      <= '0;
         r_idx       <= '0;
         for (int i = 0; i < TB_DEPTH; i++) r_buf[i] <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_cur_state <= w_start_state;
                  r_addr      <= i_base_addr;
                  r_step      <= '0;
               end
            end
            S_TRACE: begin
               r_buf[r_step[IDX_W-1:0]] <= r_cur_state[OUT_BITS-1:0];
               r_cur_state <= w_prev_state;
               r_addr      <= (r_addr == '0) ? ADDR_W'(MEM_DEPTH-1) : r_addr - 1'b1;
               if (w_last_step) r_idx  <= '0;
               else             r_step <= r_step + 1'b1;
            end
            S_OUTPUT: begin
               if (i_ready) r_idx <= r_idx + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_traceback_unit.sv
// Bench for traceback_unit (STATE_W=3, TB_DEPTH=4, OUT_BITS=2, MEM_DEPTH=8).
module tb_traceback_unit;
   localparam int SW  = 3;
   localparam int TD  = 4;
   localparam int OB  = 2;
   localparam int MD  = 8;
   localparam int PW  = 8;
   localparam int NS  = 8;
   localparam int AW  = 3;
   localparam int SDW = NS*SW;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            i_start = 1'b0;
   logic [SW-1:0]   i_start_state = '0;
   logic [AW-1:0]   i_base_addr = '0;
   logic [SDW-1:0]  i_surv_data;
   logic            i_ready = 1'b1;
   logic [NS*PW-1:0] i_path_metric = '0;
   logic            o_rd_en, o_valid, o_busy, o_done;
   logic [AW-1:0]   o_rd_addr;
   logic [OB-1:0]   o_data;

   traceback_unit #(.STATE_W(SW), .TB_DEPTH(TD), .OUT_BITS(OB), .MEM_DEPTH(MD), .PM_W(PW)) dut (
      .clk(clk), .rst(rst), .i_start(i_start), .i_start_state(i_start_state),
      .i_base_addr(i_base_addr), .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr),
      .i_surv_data(i_surv_data), .o_valid(o_valid), .i_ready(i_ready),
      .o_data(o_data), .o_busy(o_busy), .o_done(o_done), .i_path_metric(i_path_metric)
   );

   always #5 clk = ~clk;

   // Survivor memory model: one-cycle read latency, garbage otherwise.
   logic [SDW-1:0] mem [MD];
   always @(posedge clk) begin
      if (o_rd_en) i_surv_data <= mem[o_rd_addr];
      else         i_surv_data <= SDW'($urandom);
   end

   int errors = 0;
   int checks = 0;
   int exp_addr[4];
   int exp_data[4];
   bit use_pm = 1'b0;

   typedef struct packed {
      logic [1:0]       kind;
      logic [2:0]       start;
      logic [2:0]       base;
      logic [1:0]       mode;
      logic [3:0][2:0]  addrs;
      logic [3:0][1:0]  data;
   } vec_t;
   vec_t vecs[5];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_table(input int kind);
      for (int a = 0; a < MD; a++)
         for (int s = 0; s < NS; s++)
            case (kind)
               0:       mem[a][s*SW +: SW] = SW'(s);
               1:       mem[a][s*SW +: SW] = SW'((s + 1) % NS);
               default: mem[a][s*SW +: SW] = SW'((s + NS - 1) % NS);
            endcase
   endtask

   // Reference: follow prev pointers from the end state, newest address first.
   task automatic model(input int start, input int base);
      int s;
      int a;
      int bits[4];
      s = start;
      for (int k = 0; k < TD; k++) begin
         a = (base - k + MD) % MD;
         exp_addr[k] = a;
         bits[k] = s % (1 << OB);
         s = int'(mem[a][s*SW +: SW]);
      end
      for (int j = 0; j < TD; j++) exp_data[j] = bits[TD-1-j];
   endtask

   function automatic int argmin_pm();
      int mn;
      mn = 1000;
      for (int s = 0; s < NS; s++) if (int'(i_path_metric[s*PW +: PW]) < mn) mn = int'(i_path_metric[s*PW +: PW]);
      for (int s = 0; s < NS; s++) if (int'(i_path_metric[s*PW +: PW]) == mn) return s;
      return 0;
   endfunction

   // mode 0: always ready; 1: 5-cycle stall on beat 2 plus start pulses while busy; 2: random ready
   task automatic run_case(input string tag, input int start, input int base, input int mode);
      int addrs[$];
      int beats[$];
      int first_v, done_k, last_hs, stalls, unstable, busy_low, valid_at_done, k, pdata, spurious;
      bit pending;
      first_v = -1; done_k = -1; last_hs = -1; stalls = 0; unstable = 0;
      busy_low = 0; valid_at_done = 0; pending = 1'b0; pdata = 0; spurious = 0;
      i_start_state = SW'(start);
      i_base_addr   = AW'(base);
      if (!use_pm)
         for (int s = 0; s < NS; s++) i_path_metric[s*PW +: PW] = (s == start) ? 8'd1 : 8'd200;
      i_ready = 1'b1;
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      for (k = 1; k <= 150 && done_k < 0; k++) begin
         @(negedge clk);
         if (!o_busy) busy_low++;
         if (o_rd_en) addrs.push_back(int'(o_rd_addr));
         if (o_valid && first_v < 0) first_v = k;
         if (pending && int'(o_data) != pdata) unstable++;
         pending = o_valid && !i_ready;
         pdata = int'(o_data);
         if (o_valid && i_ready) begin
            beats.push_back(int'(o_data));
            last_hs = k;
         end
         if (o_done) begin
            done_k = k;
            valid_at_done = int'(o_valid);
         end
         tick();
         case (mode)
            1: begin
               if (beats.size() == 1 && stalls < 5) begin
                  i_ready = 1'b0;
                  stalls++;
               end else i_ready = 1'b1;
            end
            2: i_ready = 1'($urandom_range(0, 1));
            default: i_ready = 1'b1;
         endcase
         if (mode == 1 && (k == 3 || k == 10)) begin
            i_start = 1'b1;
            i_start_state = ~SW'(start);
         end else begin
            i_start = 1'b0;
         end
      end
      i_start = 1'b0;
      i_ready = 1'b1;
      chk({tag, " rd_count"}, addrs.size(), TD);
      for (int i = 0; i < TD; i++)
         chk($sformatf("%s addr%0d", tag, i), (i < addrs.size()) ? addrs[i] : -1, exp_addr[i]);
      chk({tag, " beat_count"}, beats.size(), TD);
      for (int i = 0; i < TD; i++)
         chk($sformatf("%s data%0d", tag, i), (i < beats.size()) ? beats[i] : -1, exp_data[i]);
      chk({tag, " first_valid_cycle"}, first_v, 2*TD + 1);
      chk({tag, " done_after_last_beat"}, done_k - last_hs, 1);
      chk({tag, " valid_during_done"}, valid_at_done, 0);
      chk({tag, " busy_low_in_run"}, busy_low, 0);
      chk({tag, " data_unstable"}, unstable, 0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (o_busy || o_rd_en || o_valid || o_done) spurious++;
         tick();
      end
      chk({tag, " idle_after_done"}, spurious, 0);
      $display("run %s start=%0d base=%0d beats=%0d first_valid=%0d done=%0d", tag, start, base,
               beats.size(), first_v, done_k);
   endtask

   int vcnt;
   int eff;

   initial begin
      vecs[0] = {2'd0, 3'd5, 3'd3, 2'd0, 3'd0, 3'd1, 3'd2, 3'd3, 2'd1, 2'd1, 2'd1, 2'd1};
      vecs[1] = {2'd1, 3'd0, 3'd5, 2'd0, 3'd2, 3'd3, 3'd4, 3'd5, 2'd0, 2'd1, 2'd2, 2'd3};
      vecs[2] = {2'd0, 3'd6, 3'd1, 2'd0, 3'd6, 3'd7, 3'd0, 3'd1, 2'd2, 2'd2, 2'd2, 2'd2};
      vecs[3] = {2'd2, 3'd2, 3'd0, 2'd0, 3'd5, 3'd6, 3'd7, 3'd0, 2'd2, 2'd1, 2'd0, 2'd3};
      vecs[4] = {2'd1, 3'd0, 3'd3, 2'd1, 3'd0, 3'd1, 3'd2, 3'd3, 2'd0, 2'd1, 2'd2, 2'd3};

      fill_table(0);
      rst = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      chk("reset rd_en", int'(o_rd_en), 0);
      chk("reset rd_addr", int'(o_rd_addr), 0);
      chk("reset valid", int'(o_valid), 0);
      chk("reset data", int'(o_data), 0);
      chk("reset busy", int'(o_busy), 0);
      chk("reset done", int'(o_done), 0);
      tick();
      rst = 1'b1;
      tick();

      for (int v = 0; v < 5; v++) begin
         fill_table(int'(vecs[v].kind));
         for (int i = 0; i < TD; i++) begin
            exp_addr[i] = int'(vecs[v].addrs[i]);
            exp_data[i] = int'(vecs[v].data[i]);
         end
         run_case($sformatf("vec%0d", v), int'(vecs[v].start), int'(vecs[v].base), int'(vecs[v].mode));
      end

      // Reset asserted during the second TRACE cycle.
      fill_table(0);
      i_start_state = 3'd5;
      i_base_addr = 3'd3;
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      tick();
      tick();
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("midrst trace_busy", int'(o_busy), 1);
      chk("midrst trace_rd_en", int'(o_rd_en), 0);
      tick();
      rst = 1'b1;
      @(negedge clk);
      chk("midrst rd_en", int'(o_rd_en), 0);
      chk("midrst rd_addr", int'(o_rd_addr), 0);
      chk("midrst valid", int'(o_valid), 0);
      chk("midrst data", int'(o_data), 0);
      chk("midrst busy", int'(o_busy), 0);
      chk("midrst done", int'(o_done), 0);
      vcnt = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         @(negedge clk);
         if (o_valid || o_busy || o_done) vcnt++;
      end
      chk("midrst no_partial_output", vcnt, 0);
      tick();
      model(5, 3);
      run_case("after_reset", 5, 3, 0);

`ifdef TB_BEST_STATE_EN
      fill_table(0);
      use_pm = 1'b1;
      i_path_metric = {8'd6, 8'd5, 8'd4, 8'd8, 8'd4, 8'd7, 8'd7, 8'd9};
      model(3, 2);
      run_case("best_state", 0, 2, 0);
      use_pm = 1'b0;
`endif

      for (int r = 0; r < 10; r++) begin
         for (int a = 0; a < MD; a++)
            for (int s = 0; s < NS; s++) mem[a][s*SW +: SW] = SW'($urandom_range(0, NS-1));
         use_pm = 1'b1;
         for (int s = 0; s < NS; s++) i_path_metric[s*PW +: PW] = PW'($urandom_range(0, 255));
         eff = $urandom_range(0, NS-1);
         i_base_addr = AW'($urandom_range(0, MD-1));
`ifdef TB_BEST_STATE_EN
         model(argmin_pm(), int'(i_base_addr));
`else
         model(eff, int'(i_base_addr));
`endif
         run_case($sformatf("rand%0d", r), eff, int'(i_base_addr), 2);
         use_pm = 1'b0;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
endmodule
